// File: rtl/seq_pattern_detector_if.sv
// Bus bundle for seq_pattern_detector: serial data, configuration strobe and
// detector status. The master drives data/config and the slave is the detector.
interface seq_pattern_detector_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
);
   logic               data_in;
   logic               data_valid;
   logic               cfg_load;
   logic [MAX_LEN-1:0] pattern;
   logic [LEN_W-1:0]   pat_len;
   logic               overlap;
   logic               detected;
   logic [CNT_W-1:0]   match_count;
   logic               armed;
   logic               cfg_err;

   modport master (
      output data_in, data_valid, cfg_load, pattern, pat_len, overlap,
      input  detected, match_count, armed, cfg_err
   );

   modport slave (
      input  data_in, data_valid, cfg_load, pattern, pat_len, overlap,
      output detected, match_count, armed, cfg_err
   );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-loaded pattern of 1..MAX_LEN bits,
// optional overlapping matches and a registered one-cycle detect pulse.
// Optional feature macro: SEQDET_COUNT_EN enables the saturating match counter;
// without it match_count is held at zero.
module seq_pattern_detector #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   seq_pattern_detector_if.slave  bus
);

   typedef enum logic {IDLE, ARMED} state_t;

   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W:0]   FILL_ONE = (LEN_W+1)'(1);

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               det_q, det_d;
   logic               err_q, err_d;

   logic               cfg_legal;
   logic               accept;
   logic               match;
   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] len_mask;

   // Legality of the incoming configuration, accepted-bit qualifier and match test
   always_comb begin
      cfg_legal = (bus.pat_len != '0) && (32'(bus.pat_len) <= MAX_LEN);
      accept    = (state_q == ARMED) && bus.data_valid && !bus.cfg_load;
      cand      = {hist_q[MAX_LEN-2:0], bus.data_in};
      len_mask  = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < 32'(len_q));
      end
      match = accept
           && (((cand ^ pat_q) & len_mask) == '0)
           && (({1'b0, fill_q} + FILL_ONE) >= {1'b0, len_q});
   end

   // Next-state and output logic; cfg_load wins over any coincident data bit
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      det_d   = 1'b0;
      err_d   = 1'b0;
      if (bus.cfg_load) begin
         hist_d = '0;
         fill_d = '0;
         if (cfg_legal) begin
            state_d = ARMED;
            pat_d   = bus.pattern;
            len_d   = bus.pat_len;
            ovl_d   = bus.overlap;
         end else begin
            state_d = IDLE;
            err_d   = 1'b1;
         end
      end else if (accept) begin
         hist_d = cand;
         if (32'(fill_q) < MAX_LEN) begin
            fill_d = fill_q + LEN_ONE;
         end
         if (match) begin
            det_d = 1'b1;
            if (!ovl_q) begin
               fill_d = '0;
            end
         end
      end
   end

   // State, configuration and history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         det_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         det_q   <= det_d;
         err_q   <= err_d;
      end
   end

   assign bus.detected = det_q;
   assign bus.cfg_err  = err_q;
   assign bus.armed    = (state_q == ARMED);

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating match counter, cleared by every cfg_load
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cfg_load) begin
         cnt_d = '0;
      end else if (match && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.match_count = cnt_q;
`else
   assign bus.match_count = {CNT_W{1'b0}};
`endif

endmodule
